pixel_stream_checker: RTL and testbench

//  Synthesizable self-checking monitor for the image engine's pixel stream.
//  - Each accepted input pixel is queued together with the mode active when it arrived.
//  - Each output pixel is matched against its queued input in arrival order.
//  - Bypass, invert and threshold modes are compared against a built-in model.

---
 rtl/pix_chk_pkg.sv | 37 +++
 rtl/pix_ref_fifo.sv | 65 ++++++
 rtl/pixel_stream_checker.sv | 210 +++++++++++++++++++++
 tb/tb_pixel_stream_checker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_chk_pkg.sv
// Shared definitions for the pixel stream checker.
//   - Mode encodings of the image engine.
//   - Reference entry layout (mode, threshold, pixel) in a width-independent form.
//     Fields are 32 bits wide, so pixel widths up to 32 bits are supported.
//   - expected_pix(): the checker's built-in model of the engine.
package pix_chk_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_INVERT = 2'b01;
    localparam logic [1:0] MODE_CONV   = 2'b10;
    localparam logic [1:0] MODE_THRESH = 2'b11;

    // One queued input pixel together with the mode and threshold active when it arrived.
    // The engine's pixel width is zero-extended into these fields.
    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] thr;
        logic [31:0] pix;
    } ref_entry_t;

    // Expected engine output for one entry. pix_w is the real pixel width and sets
    // the all-ones value. Convolution is not modelled and returns 0.
    function automatic logic [31:0] expected_pix(input ref_entry_t e, input int unsigned pix_w);
        logic [31:0] ones;
        logic [31:0] res;
        ones = (pix_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pix_w) - 32'd1);
        res  = '0;
        case (e.mode)
            MODE_BYPASS: res = e.pix;
            MODE_INVERT: res = ones - e.pix;
            MODE_THRESH: res = (e.pix >= e.thr) ? ones : '0;
            default:     res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pix_ref_fifo.sv
// Reference FIFO for the pixel stream checker, first-word-fall-through.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset (empties the FIFO)
//   push, din    store din unless full (a same-cycle pop on a full FIFO frees the slot)
//   pop          discard the head entry; ignored when empty
//   dout         current head entry (valid whenever empty is low)
//   full, empty  occupancy flags
//   level        entries queued, 0..DEPTH
module pix_ref_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];

    // Pointers carry one extra MSB so that equal low bits can mean empty or full.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;

    // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (level == (AW+1)'(DEPTH));
        pop_ok   = pop & ~empty;
        // A pop in the same cycle makes room, so a full FIFO still accepts the push.
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    // On a full push+pop the write lands on the slot being read, and dout still shows the old word.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pixel_stream_checker.sv
// Self-checking monitor for the image engine's pixel stream.
// Every accepted input pixel is queued with its mode and threshold; every output pixel
// is matched against the oldest queued entry and compared with the built-in model
// (convolution pixels are counted only). Results are registered one cycle after out_valid.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   clear            clears counters, flags and first-error capture; the FIFO is kept
//   mode, thresh     engine mode and threshold, sampled with each pushed pixel
//   in_valid/pixel   engine input accepted (push)
//   out_valid/pixel  engine output produced (pop and compare)
//   pix_count        output pixels seen
//   checked_count    output pixels compared
//   mismatch_count   compared pixels that differed
//   err_sticky       any mismatch, overflow or underflow
//   ovf, unf         sticky: push dropped on full / pop on empty
//   first_err_*      pix_count, received and expected value of the first mismatch
//   fifo_level       entries currently queued
module pixel_stream_checker
    import pix_chk_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [1:0]             mode,
    input  logic [PIX_W-1:0]       thresh,
    input  logic                   in_valid,
    input  logic [PIX_W-1:0]       in_pixel,
    input  logic                   out_valid,
    input  logic [PIX_W-1:0]       out_pixel,
    output logic [CNT_W-1:0]       pix_count,
    output logic [CNT_W-1:0]       checked_count,
    output logic [CNT_W-1:0]       mismatch_count,
    output logic                   err_sticky,
    output logic                   ovf,
    output logic                   unf,
    output logic [CNT_W-1:0]       first_err_idx,
    output logic [PIX_W-1:0]       first_err_got,
    output logic [PIX_W-1:0]       first_err_exp,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int ENT_W = 2 + 2*PIX_W;

    logic [ENT_W-1:0] push_entry;
    logic [ENT_W-1:0] head;
    logic             fifo_full, fifo_empty;
    ref_entry_t       head_entry;
    logic [PIX_W-1:0] exp_pix;

    assign push_entry = {mode, thresh, in_pixel};

    pix_ref_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_ref_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (out_valid),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        head_entry.mode = head[ENT_W-1 -: 2];
        head_entry.thr  = 32'(head[2*PIX_W-1 -: PIX_W]);
        head_entry.pix  = 32'(head[PIX_W-1:0]);
        exp_pix         = PIX_W'(expected_pix(head_entry, PIX_W));
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Compare stage: one cycle of registered events per output pixel.
    logic             ev;
    logic             st_valid_q, st_valid_d;
    logic             st_unf_q,   st_unf_d;
    logic             st_chk_q,   st_chk_d;
    logic             st_mis_q,   st_mis_d;
    logic             st_ovf_q,   st_ovf_d;
    logic [PIX_W-1:0] st_got_q,   st_got_d;
    logic [PIX_W-1:0] st_exp_q,   st_exp_d;

    // Status registers.
    logic [CNT_W-1:0] pix_cnt_q,  pix_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q,  chk_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q,  mis_cnt_d;
    logic             ovf_q,      ovf_d;
    logic             unf_q,      unf_d;
    logic             err_q,      err_d;
    logic             cap_done_q, cap_done_d;
    logic [CNT_W-1:0] cap_idx_q,  cap_idx_d;
    logic [PIX_W-1:0] cap_got_q,  cap_got_d;
    logic [PIX_W-1:0] cap_exp_q,  cap_exp_d;

    // Events seen during a clear cycle are discarded so that clear always wins.
    always_comb begin
        ev       = out_valid & ~clear;
        st_valid_d = ev;
        st_unf_d = ev & fifo_empty;
        st_chk_d = ev & ~fifo_empty & (head_entry.mode != MODE_CONV);
        st_mis_d = st_chk_d & (out_pixel != exp_pix);
        // Drop happens only when full and no pop frees a slot this cycle.
        st_ovf_d = in_valid & ~out_valid & fifo_full & ~clear;
        st_got_d = out_pixel;
        st_exp_d = exp_pix;
    end

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        chk_cnt_d  = chk_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        ovf_d      = ovf_q | st_ovf_q;
        unf_d      = unf_q | st_unf_q;
        err_d      = err_q | st_mis_q | st_ovf_q | st_unf_q;
        cap_done_d = cap_done_q;
        cap_idx_d  = cap_idx_q;
        cap_got_d  = cap_got_q;
        cap_exp_d  = cap_exp_q;

        if (st_valid_q) begin
            pix_cnt_d = sat_inc(pix_cnt_q);
        end
        if (st_chk_q) begin
            chk_cnt_d = sat_inc(chk_cnt_q);
        end
        if (st_mis_q) begin
            mis_cnt_d = sat_inc(mis_cnt_q);
            // Index is the pixel count before this pixel is added.
            if (!cap_done_q) begin
                cap_done_d = 1'b1;
                cap_idx_d  = pix_cnt_q;
                cap_got_d  = st_got_q;
                cap_exp_d  = st_exp_q;
            end
        end

        if (clear) begin
            pix_cnt_d  = '0;
            chk_cnt_d  = '0;
            mis_cnt_d  = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
            err_d      = 1'b0;
            cap_done_d = 1'b0;
            cap_idx_d  = '0;
            cap_got_d  = '0;
            cap_exp_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid_q <= 1'b0;
            st_unf_q   <= 1'b0;
            st_chk_q   <= 1'b0;
            st_mis_q   <= 1'b0;
            st_ovf_q   <= 1'b0;
            st_got_q   <= '0;
            st_exp_q   <= '0;
            pix_cnt_q  <= '0;
            chk_cnt_q  <= '0;
            mis_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            err_q      <= 1'b0;
            cap_done_q <= 1'b0;
            cap_idx_q  <= '0;
            cap_got_q  <= '0;
            cap_exp_q  <= '0;
        end else begin
            st_valid_q <= st_valid_d;
            st_unf_q   <= st_unf_d;
            st_chk_q   <= st_chk_d;
            st_mis_q   <= st_mis_d;
            st_ovf_q   <= st_ovf_d;
            st_got_q   <= st_got_d;
            st_exp_q   <= st_exp_d;
            pix_cnt_q  <= pix_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            err_q      <= err_d;
            cap_done_q <= cap_done_d;
            cap_idx_q  <= cap_idx_d;
            cap_got_q  <= cap_got_d;
            cap_exp_q  <= cap_exp_d;
        end
    end

    assign pix_count      = pix_cnt_q;
    assign checked_count  = chk_cnt_q;
    assign mismatch_count = mis_cnt_q;
    assign err_sticky     = err_q;
    assign ovf            = ovf_q;
    assign unf            = unf_q;
    assign first_err_idx  = cap_idx_q;
    assign first_err_got  = cap_got_q;
    assign first_err_exp  = cap_exp_q;

endmodule

// File: tb/tb_pixel_stream_checker.sv
// Bench for pixel_stream_checker: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the engine and the checker's counters.
module tb_pixel_stream_checker;

    localparam int PIX_W = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset, clear, in_valid, out_valid;
    logic [1:0]       mode;
    logic [7:0]       thresh, in_pixel, out_pixel;
    logic [31:0]      pix_count, checked_count, mismatch_count, first_err_idx;
    logic             err_sticky, ovf, unf;
    logic [7:0]       first_err_got, first_err_exp;
    logic [4:0]       fifo_level;

    pixel_stream_checker #(.PIX_W(PIX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .clear(clear), .mode(mode), .thresh(thresh),
        .in_valid(in_valid), .in_pixel(in_pixel), .out_valid(out_valid), .out_pixel(out_pixel),
        .pix_count(pix_count), .checked_count(checked_count), .mismatch_count(mismatch_count),
        .err_sticky(err_sticky), .ovf(ovf), .unf(unf), .first_err_idx(first_err_idx),
        .first_err_got(first_err_got), .first_err_exp(first_err_exp), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: queue of pending input pixels plus the expected status.
    typedef struct {
        logic [1:0] mode;
        logic [7:0] thr;
        logic [7:0] pix;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pix, m_chk, m_mis, m_idx;
    logic        m_ovf, m_unf, m_err, m_cap;
    logic [7:0]  m_got, m_exp;

    function automatic logic [7:0] ref_exp(input ent_t e);
        case (e.mode)
            2'b00:   return e.pix;
            2'b01:   return 8'd255 - e.pix;
            2'b11:   return (e.pix >= e.thr) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] head_exp();
        if (mq.size() == 0) return 8'h00;
        return ref_exp(mq[0]);
    endfunction

    task automatic model_clear();
        m_pix = 0; m_chk = 0; m_mis = 0; m_idx = 0;
        m_ovf = 0; m_unf = 0; m_err = 0; m_cap = 0;
        m_got = 0; m_exp = 0;
    endtask

    // One clock cycle of engine traffic; the model is updated with the pre-edge state.
    task automatic step(input bit iv, input logic [7:0] ip, input bit ov, input logic [7:0] op);
        ent_t e;
        in_valid = iv; in_pixel = ip; out_valid = ov; out_pixel = op;
        if (ov) begin
            if (mq.size() == 0) begin
                m_unf = 1; m_err = 1;
            end else begin
                e = mq.pop_front();
                if (e.mode != 2'b10) begin
                    m_chk++;
                    if (op !== ref_exp(e)) begin
                        m_mis++; m_err = 1;
                        if (!m_cap) begin
                            m_cap = 1; m_idx = m_pix; m_got = op; m_exp = ref_exp(e);
                        end
                    end
                end
            end
            m_pix++;
        end
        if (iv) begin
            if (mq.size() < DEPTH) mq.push_back('{mode, thresh, ip});
            else begin m_ovf = 1; m_err = 1; end
        end
        @(posedge clk); #1;
        in_valid = 0; out_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00);
    endtask

    task automatic do_clear();
        clear = 1; model_clear();
        @(posedge clk); #1;
        clear = 0;
    endtask

    task automatic do_reset();
        reset = 1; model_clear(); mq.delete();
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset(); do_reset();
        tests_run++; if (pix_count !== 32'd0) begin tests_failed++; $display("FAIL reset.pix_count got %0d expected 0", pix_count); end
        tests_run++; if (checked_count !== 32'd0) begin tests_failed++; $display("FAIL reset.checked_count got %0d expected 0", checked_count); end
        tests_run++; if (mismatch_count !== 32'd0) begin tests_failed++; $display("FAIL reset.mismatch_count got %0d expected 0", mismatch_count); end
        tests_run++; if ({err_sticky, ovf, unf} !== 3'b000) begin tests_failed++; $display("FAIL reset.flags got %b expected 000", {err_sticky, ovf, unf}); end
        tests_run++; if (first_err_idx !== 32'd0) begin tests_failed++; $display("FAIL reset.first_err_idx got %0d expected 0", first_err_idx); end
        tests_run++; if ({first_err_got, first_err_exp} !== 16'h0) begin tests_failed++; $display("FAIL reset.first_err_data got %h expected 0000", {first_err_got, first_err_exp}); end
        tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL reset.fifo_level got %0d expected 0", fifo_level); end
    endtask

    task automatic test_bypass();
        do_clear(); mode = 2'b00;
        for (int c = 0; c < 53; c++)
            step(c < 50, 8'(c), c >= 3, 8'(c - 3));
        idle(2);
        tests_run++; if (pix_count !== 32'd50) begin tests_failed++; $display("FAIL bypass.pix_count got %0d expected 50", pix_count); end
        tests_run++; if (checked_count !== 32'd50) begin tests_failed++; $display("FAIL bypass.checked_count got %0d expected 50", checked_count); end
        tests_run++; if (mismatch_count !== 32'd0) begin tests_failed++; $display("FAIL bypass.mismatch_count got %0d expected 0", mismatch_count); end
        tests_run++; if (err_sticky !== 1'b0) begin tests_failed++; $display("FAIL bypass.err_sticky got %b expected 0", err_sticky); end
        tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL bypass.fifo_level got %0d expected 0", fifo_level); end
    endtask

    task automatic test_invert();
        do_clear(); mode = 2'b01;
        // Pops 0..6 are correct, pop index 7 returns a corrupted value.
        for (int c = 0; c < 9; c++)
            step(c < 8, 8'h3C, c >= 1, (c == 8) ? 8'hC2 : 8'hC3);
        idle(2);
        tests_run++; if (mismatch_count !== 32'd1) begin tests_failed++; $display("FAIL invert.mismatch_count got %0d expected 1", mismatch_count); end
        tests_run++; if (checked_count !== 32'd8) begin tests_failed++; $display("FAIL invert.checked_count got %0d expected 8", checked_count); end
        tests_run++; if (first_err_idx !== 32'd7) begin tests_failed++; $display("FAIL invert.first_err_idx got %0d expected 7", first_err_idx); end
        tests_run++; if (first_err_got !== 8'hC2) begin tests_failed++; $display("FAIL invert.first_err_got got %h expected c2", first_err_got); end
        tests_run++; if (first_err_exp !== 8'hC3) begin tests_failed++; $display("FAIL invert.first_err_exp got %h expected c3", first_err_exp); end
        tests_run++; if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL invert.err_sticky got %b expected 1", err_sticky); end
    endtask

    task automatic test_mode_switch();
        logic [7:0] p [8];
        do_clear(); mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            p[i] = 8'($urandom_range(255));
            if (i == 4) mode = 2'b01;
            step(1, p[i], 0, 8'h00);
        end
        for (int i = 0; i < 8; i++)
            step(0, 8'h00, 1, (i < 4) ? p[i] : 8'd255 - p[i]);
        idle(2);
        tests_run++; if (mismatch_count !== 32'd0) begin tests_failed++; $display("FAIL mode_switch.mismatch_count got %0d expected 0", mismatch_count); end
        tests_run++; if (checked_count !== 32'd8) begin tests_failed++; $display("FAIL mode_switch.checked_count got %0d expected 8", checked_count); end
    endtask

    task automatic test_threshold();
        do_clear(); mode = 2'b11; thresh = 8'h80;
        step(1, 8'h7F, 0, 8'h00);
        step(1, 8'h80, 0, 8'h00);
        mode = 2'b10;
        step(1, 8'($urandom_range(255)), 0, 8'h00);
        step(1, 8'($urandom_range(255)), 0, 8'h00);
        step(0, 8'h00, 1, 8'h00);
        step(0, 8'h00, 1, 8'hFF);
        step(0, 8'h00, 1, 8'($urandom_range(255)));
        step(0, 8'h00, 1, 8'($urandom_range(255)));
        idle(2);
        tests_run++; if (pix_count !== 32'd4) begin tests_failed++; $display("FAIL thresh.pix_count got %0d expected 4", pix_count); end
        tests_run++; if (checked_count !== 32'd2) begin tests_failed++; $display("FAIL thresh.checked_count got %0d expected 2", checked_count); end
        tests_run++; if (mismatch_count !== 32'd0) begin tests_failed++; $display("FAIL thresh.mismatch_count got %0d expected 0", mismatch_count); end
        // Pixel equal to the threshold must map to all-ones.
        mode = 2'b11;
        step(1, 8'h80, 0, 8'h00);
        step(0, 8'h00, 1, 8'h00);
        idle(2);
        tests_run++; if (mismatch_count !== 32'd1) begin tests_failed++; $display("FAIL thresh_eq.mismatch_count got %0d expected 1", mismatch_count); end
        tests_run++; if (first_err_exp !== 8'hFF) begin tests_failed++; $display("FAIL thresh_eq.first_err_exp got %h expected ff", first_err_exp); end
        tests_run++; if (first_err_idx !== 32'd4) begin tests_failed++; $display("FAIL thresh_eq.first_err_idx got %0d expected 4", first_err_idx); end
    endtask

    task automatic test_overflow_underflow();
        do_clear(); mode = 2'b00;
        for (int i = 0; i < DEPTH + 1; i++) step(1, 8'(8'h40 + i), 0, 8'h00);
        idle(2);
        tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf.ovf got %b expected 1", ovf); end
        tests_run++; if (fifo_level !== 5'(DEPTH)) begin tests_failed++; $display("FAIL ovf.fifo_level got %0d expected %0d", fifo_level, DEPTH); end
        tests_run++; if (err_sticky !== 1'b1) begin tests_failed++; $display("FAIL ovf.err_sticky got %b expected 1", err_sticky); end
        tests_run++; if (unf !== 1'b0) begin tests_failed++; $display("FAIL ovf.unf got %b expected 0", unf); end
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, head_exp());
        idle(1);
        step(0, 8'h00, 1, 8'h55);
        idle(2);
        tests_run++; if (unf !== 1'b1) begin tests_failed++; $display("FAIL unf.unf got %b expected 1", unf); end
        tests_run++; if (pix_count !== 32'(DEPTH + 1)) begin tests_failed++; $display("FAIL unf.pix_count got %0d expected %0d", pix_count, DEPTH + 1); end
        tests_run++; if (mismatch_count !== 32'd0) begin tests_failed++; $display("FAIL unf.mismatch_count got %0d expected 0", mismatch_count); end
        tests_run++; if (checked_count !== 32'(DEPTH)) begin tests_failed++; $display("FAIL unf.checked_count got %0d expected %0d", checked_count, DEPTH); end
        for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 8'h00);
        idle(1);
        do_clear();
        idle(1);
        tests_run++; if ({pix_count, checked_count, mismatch_count} !== 96'd0) begin tests_failed++; $display("FAIL clear.counters got %h expected 0", {pix_count, checked_count, mismatch_count}); end
        tests_run++; if ({err_sticky, ovf, unf} !== 3'b000) begin tests_failed++; $display("FAIL clear.flags got %b expected 000", {err_sticky, ovf, unf}); end
        tests_run++; if (fifo_level !== 5'd3) begin tests_failed++; $display("FAIL clear.fifo_level got %0d expected 3", fifo_level); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 8'h00);
        step(0, 8'h00, 1, ~head_exp());
        idle(2);
        tests_run++; if (fifo_level !== 5'd5) begin tests_failed++; $display("FAIL midreset.pre_level got %0d expected 5", fifo_level); end
        tests_run++; if (mismatch_count !== 32'd1) begin tests_failed++; $display("FAIL midreset.pre_mismatch got %0d expected 1", mismatch_count); end
        do_reset();
        tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL midreset.fifo_level got %0d expected 0", fifo_level); end
        tests_run++; if ({pix_count, checked_count, mismatch_count, first_err_idx} !== 128'd0) begin tests_failed++; $display("FAIL midreset.counters got %h expected 0", {pix_count, checked_count, mismatch_count, first_err_idx}); end
        tests_run++; if ({err_sticky, ovf, unf, first_err_got, first_err_exp} !== 19'd0) begin tests_failed++; $display("FAIL midreset.flags got %h expected 0", {err_sticky, ovf, unf, first_err_got, first_err_exp}); end
    endtask

    task automatic test_back_to_back_full();
        do_clear(); mode = 2'b01;
        for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom_range(255)), 0, 8'h00);
        step(1, 8'h11, 1, head_exp());
        idle(2);
        tests_run++; if (fifo_level !== 5'(DEPTH)) begin tests_failed++; $display("FAIL full_pushpop.fifo_level got %0d expected %0d", fifo_level, DEPTH); end
        tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL full_pushpop.ovf got %b expected 0", ovf); end
        tests_run++; if (mismatch_count !== 32'd0) begin tests_failed++; $display("FAIL full_pushpop.mismatch_count got %0d expected 0", mismatch_count); end
        // Drain: the last entry (0x11) checks that the wrapped write landed correctly.
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, head_exp());
        idle(2);
        tests_run++; if (mismatch_count !== 32'd0) begin tests_failed++; $display("FAIL full_drain.mismatch_count got %0d expected 0", mismatch_count); end
        tests_run++; if (checked_count !== 32'(DEPTH + 1)) begin tests_failed++; $display("FAIL full_drain.checked_count got %0d expected %0d", checked_count, DEPTH + 1); end
    endtask

    task automatic test_random();
        bit         iv, ov;
        logic [7:0] op;
        do_clear();
        for (int c = 0; c < 400; c++) begin
            mode   = 2'($urandom_range(3));
            thresh = 8'($urandom_range(255));
            iv = (mq.size() < DEPTH - 2) && ($urandom_range(99) < 60);
            ov = (mq.size() > 0) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 3);
            op = (mq.size() > 0 && mq[0].mode == 2'b10) ? 8'($urandom_range(255)) : head_exp();
            if ($urandom_range(9) == 0) op = op ^ 8'($urandom_range(255, 1));
            step(iv, 8'($urandom_range(255)), ov, op);
        end
        idle(2);
        tests_run++; if (pix_count !== m_pix) begin tests_failed++; $display("FAIL random.pix_count got %0d expected %0d", pix_count, m_pix); end
        tests_run++; if (checked_count !== m_chk) begin tests_failed++; $display("FAIL random.checked_count got %0d expected %0d", checked_count, m_chk); end
        tests_run++; if (mismatch_count !== m_mis) begin tests_failed++; $display("FAIL random.mismatch_count got %0d expected %0d", mismatch_count, m_mis); end
        tests_run++; if ({err_sticky, ovf, unf} !== {m_err, m_ovf, m_unf}) begin tests_failed++; $display("FAIL random.flags got %b expected %b", {err_sticky, ovf, unf}, {m_err, m_ovf, m_unf}); end
        tests_run++; if (first_err_idx !== m_idx) begin tests_failed++; $display("FAIL random.first_err_idx got %0d expected %0d", first_err_idx, m_idx); end
        tests_run++; if ({first_err_got, first_err_exp} !== {m_got, m_exp}) begin tests_failed++; $display("FAIL random.first_err_data got %h expected %h", {first_err_got, first_err_exp}, {m_got, m_exp}); end
        tests_run++; if (fifo_level !== 5'(mq.size())) begin tests_failed++; $display("FAIL random.fifo_level got %0d expected %0d", fifo_level, mq.size()); end
    endtask

    initial begin
        reset = 1; clear = 0; mode = 2'b00; thresh = 8'h00;
        in_valid = 0; in_pixel = 0; out_valid = 0; out_pixel = 0;
        model_clear();
        test_reset();
        test_bypass();
        test_invert();
        test_mode_switch();
        test_threshold();
        test_overflow_underflow();
        test_reset_midstream();
        test_back_to_back_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
